// File: rtl/int_pg_ctrl.sv
// Power-gating controller for the Multiplier and Shifter units of the Exe0 Int0 slice.
// Each unit has its own ON/OFF/WAKE machine: it is gated after IDLE_TH idle cycles,
// and an instruction that needs a gated unit wakes it and is held until the unit is ON.
module int_pg_ctrl #(
    parameter int IDLE_TH  = 16,
    parameter int WAKE_LAT = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vld_i,
    input  logic [2:0] sel_module_i,
    input  logic       pg_en_i,
    output logic       stall_o,
    output logic       pg_mul_o,
    output logic       pg_sh_o,
    output logic       mul_on_o,
    output logic       sh_on_o
);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } pg_state_e;

    // Unit index 0 is the Multiplier, index 1 is the Shifter.
    localparam int         NU        = 2;
    localparam logic [2:0] SEL_MUL   = 3'b001;
    localparam logic [2:0] SEL_SH    = 3'b011;
    localparam logic [CNT_W-1:0] ICNT_LAST = CNT_W'(IDLE_TH - 1);
    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(WAKE_LAT - 1);

    pg_state_e        state_q [NU];
    pg_state_e        state_d [NU];
    logic [CNT_W-1:0] icnt_q  [NU];
    logic [CNT_W-1:0] icnt_d  [NU];
    logic [CNT_W-1:0] wcnt_q  [NU];
    logic [CNT_W-1:0] wcnt_d  [NU];

    logic [NU-1:0] req;
    logic [NU-1:0] on;

    // Decode which unit the presented instruction targets and which units are usable.
    always_comb begin
        req[0] = vld_i && (sel_module_i == SEL_MUL);
        req[1] = vld_i && (sel_module_i == SEL_SH);
        for (int u = 0; u < NU; u++) begin
            on[u] = (state_q[u] == ST_ON);
        end
    end

    // Per-unit state and counter registers; reset brings every unit straight back to ON.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (!rst_n) begin
                state_q[u] <= ST_ON;
                icnt_q[u]  <= '0;
                wcnt_q[u]  <= '0;
            end else begin
                state_q[u] <= state_d[u];
                icnt_q[u]  <= icnt_d[u];
                wcnt_q[u]  <= wcnt_d[u];
            end
        end
    end

    // Next-state logic: a use (or disabled gating) always beats the idle threshold,
    // and WAKE runs to completion regardless of pg_en_i or new requests.
    always_comb begin
        for (int u = 0; u < NU; u++) begin
            state_d[u] = state_q[u];
            icnt_d[u]  = icnt_q[u];
            wcnt_d[u]  = wcnt_q[u];
            unique case (state_q[u])
                ST_ON: begin
                    if (req[u] || !pg_en_i) begin
                        icnt_d[u] = '0;
                    end else if (icnt_q[u] == ICNT_LAST) begin
                        state_d[u] = ST_OFF;
                    end else begin
                        icnt_d[u] = icnt_q[u] + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (req[u] || !pg_en_i) begin
                        state_d[u] = ST_WAKE;
                        wcnt_d[u]  = '0;
                    end
                end
                ST_WAKE: begin
                    if (wcnt_q[u] == WCNT_LAST) begin
                        state_d[u] = ST_ON;
                        icnt_d[u]  = '0;
                    end else begin
                        wcnt_d[u] = wcnt_q[u] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[u] = ST_ON;
                    icnt_d[u]  = '0;
                    wcnt_d[u]  = '0;
                end
            endcase
        end
    end

    // Outputs decode the registered state; the stall is combinational so the
    // offending instruction is held in the same cycle it is presented.
    always_comb begin
        stall_o  = |(req & ~on);
        pg_mul_o = (state_q[0] == ST_OFF);
        pg_sh_o  = (state_q[1] == ST_OFF);
        mul_on_o = on[0];
        sh_on_o  = on[1];
    end

endmodule

// File: tb/tb_int_pg_ctrl.sv
// Self-checking bench for int_pg_ctrl: directed scenarios with explicit expected
// timing plus randomized traffic, all compared against a behavioural unit model.
module tb_int_pg_ctrl;

    localparam int IDLE_TH  = 16;
    localparam int WAKE_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld_i = 1'b0;
    logic [2:0] sel_module_i = 3'b000;
    logic       pg_en_i = 1'b1;
    logic       stall_o, pg_mul_o, pg_sh_o, mul_on_o, sh_on_o;

    int total = 0;
    int bad   = 0;

    int_pg_ctrl #(.IDLE_TH(IDLE_TH), .WAKE_LAT(WAKE_LAT), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld_i        (vld_i),
        .sel_module_i (sel_module_i),
        .pg_en_i      (pg_en_i),
        .stall_o      (stall_o),
        .pg_mul_o     (pg_mul_o),
        .pg_sh_o      (pg_sh_o),
        .mul_on_o     (mul_on_o),
        .sh_on_o      (sh_on_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: a unit is either gated, waking (cycles left), or on with
    // an idle run length.
    logic [2:0] ucode [2] = '{3'b001, 3'b011};
    bit         m_gated [2];
    int         m_wleft [2];
    int         m_idle  [2];

    function automatic bit m_req(input int u);
        return vld_i && (sel_module_i == ucode[u]);
    endfunction

    function automatic bit m_on(input int u);
        return !m_gated[u] && (m_wleft[u] == 0);
    endfunction

    // Expected {stall, pg_mul, pg_sh, mul_on, sh_on} for the current inputs.
    function automatic logic [4:0] model_out();
        logic st;
        st = (m_req(0) && !m_on(0)) || (m_req(1) && !m_on(1));
        return {st, m_gated[0], m_gated[1], m_on(0), m_on(1)};
    endfunction

    function automatic void model_step();
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_gated[u] = 1'b0;
                m_wleft[u] = 0;
                m_idle[u]  = 0;
            end else if (m_wleft[u] > 0) begin
                m_wleft[u]--;
                if (m_wleft[u] == 0) m_idle[u] = 0;
            end else if (m_gated[u]) begin
                if (m_req(u) || !pg_en_i) begin
                    m_gated[u] = 1'b0;
                    m_wleft[u] = WAKE_LAT;
                end
            end else if (m_req(u) || !pg_en_i) begin
                m_idle[u] = 0;
            end else if (m_idle[u] == IDLE_TH - 1) begin
                m_gated[u] = 1'b1;
                m_idle[u]  = 0;
            end else begin
                m_idle[u]++;
            end
        end
    endfunction

    function automatic logic [4:0] outs();
        return {stall_o, pg_mul_o, pg_sh_o, mul_on_o, sh_on_o};
    endfunction

    // Apply inputs for one cycle and move to the sampling point (negedge).
    task automatic drive(input bit r, input bit v, input logic [2:0] s, input bit e);
        rst_n = r; vld_i = v; sel_module_i = s; pg_en_i = e;
        @(negedge clk);
    endtask

    // Close the cycle: clock edge, model update with the held inputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        drive(0, 0, 3'b000, 1); tick();
        drive(0, 1, 3'b001, 1); tick();
        drive(1, 0, 3'b000, 1);
        got = outs();
        total++;
        if (got !== 5'b00011) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", got, 5'b00011);
        end
        total++;
        if (got !== model_out()) begin
            bad++; $display("FAIL reset_model got=%b exp=%b", got, model_out());
        end
        tick();
    endtask

    task automatic test_idle_gate();
        logic [4:0] got;
        drive(0, 0, 3'b000, 1); tick();
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 3'b000, 1);
            got = outs();
            total++;
            if (got !== {1'b0, k >= 16, k >= 16, k < 16, k < 16}) begin
                bad++; $display("FAIL idle_gate k=%0d got=%b exp=%b", k, got,
                                {1'b0, k >= 16, k >= 16, k < 16, k < 16});
            end
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL idle_gate_model k=%0d got=%b exp=%b", k, got, model_out());
            end
            tick();
        end
    endtask

    // Continues from both units gated.
    task automatic test_wake();
        logic [4:0] got, exp;
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, 3'b001, 1);
            got = outs();
            exp = {k <= WAKE_LAT, k == 0, 1'b1, k > WAKE_LAT, 1'b0};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL wake k=%0d got=%b exp=%b", k, got, exp);
            end
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL wake_model k=%0d got=%b exp=%b", k, got, model_out());
            end
            tick();
        end
    endtask

    task automatic test_periodic_use();
        logic [4:0] got;
        drive(0, 0, 3'b000, 1); tick();
        for (int k = 0; k < 80; k++) begin
            drive(1, (k % IDLE_TH) == IDLE_TH - 1, 3'b001, 1);
            got = outs();
            total++;
            if (got[4] !== 1'b0 || got[3] !== 1'b0 || got[1] !== 1'b1) begin
                bad++; $display("FAIL periodic k=%0d got=%b exp=00x1x", k, got);
            end
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL periodic_model k=%0d got=%b exp=%b", k, got, model_out());
            end
            tick();
        end
    endtask

    task automatic test_pg_en_drop();
        logic [4:0] got, exp;
        bit pg;
        drive(0, 0, 3'b000, 1); tick();
        for (int k = 0; k < IDLE_TH + 1; k++) begin
            drive(1, 0, 3'b000, 1); tick();
        end
        for (int k = 0; k < 41; k++) begin
            drive(1, 0, 3'b000, k >= 20);
            got = outs();
            pg  = (k == 0) || (k >= 20 + IDLE_TH);
            exp = {1'b0, pg, pg, k > WAKE_LAT && !pg, k > WAKE_LAT && !pg};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL pg_en_drop k=%0d got=%b exp=%b", k, got, exp);
            end
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL pg_en_drop_model k=%0d got=%b exp=%b", k, got, model_out());
            end
            tick();
        end
    endtask

    // Continues from both units gated.
    task automatic test_reset_in_wake();
        logic [4:0] got, exp;
        for (int k = 0; k < 6; k++) begin
            drive(k != 3, 1, 3'b011, 1);
            got = outs();
            exp = (k <= 3) ? {1'b1, 1'b1, k == 0, 1'b0, 1'b0} : 5'b00011;
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL reset_in_wake k=%0d got=%b exp=%b", k, got, exp);
            end
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL reset_in_wake_model k=%0d got=%b exp=%b", k, got, model_out());
            end
            tick();
        end
    endtask

    task automatic test_other_sel();
        logic [4:0] got;
        logic [2:0] s;
        drive(0, 0, 3'b000, 1); tick();
        for (int k = 0; k < IDLE_TH + 1; k++) begin
            drive(1, 0, 3'b000, 1); tick();
        end
        for (int k = 0; k < 16; k++) begin
            s = 3'($urandom_range(0, 7));
            while (s == 3'b001 || s == 3'b011) s = 3'($urandom_range(0, 7));
            drive(1, 1, s, 1);
            got = outs();
            total++;
            if (got !== 5'b01100) begin
                bad++; $display("FAIL other_sel sel=%b got=%b exp=%b", s, got, 5'b01100);
            end
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL other_sel_model sel=%b got=%b exp=%b", s, got, model_out());
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [4:0] got;
        logic [2:0] s;
        int dens;
        dens = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 40 == 0) dens = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       s = 3'b001;
                1:       s = 3'b011;
                default: s = 3'($urandom_range(0, 7));
            endcase
            drive($urandom_range(0, 499) != 0,
                  dens != 0 && $urandom_range(0, 15) < dens * 3,
                  s,
                  $urandom_range(0, 29) != 0);
            got = outs();
            total++;
            if (got !== model_out()) begin
                bad++; $display("FAIL random k=%0d got=%b exp=%b", k, got, model_out());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle_gate();
        test_wake();
        test_periodic_use();
        test_pg_en_drop();
        test_reset_in_wake();
        test_other_sel();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
